// File: rtl/multi_ch_blinker.sv
// multi_ch_blinker: N_CH LED pattern channels on a shared tick base.
// Optional BLINKER_PWM_DIM_EN adds a global 4-bit PWM dim input.
module multi_ch_blinker #(
  parameter int CLK_HZ   = 24000000,
  parameter int TICK_HZ  = 1000,
  parameter int N_CH     = 4,
  parameter int HALF_W   = 10,
  parameter int DEF_HALF = 500,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2*N_CH-1:0] mode,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [HALF_W-1:0] cfg_half,
`ifdef BLINKER_PWM_DIM_EN
  input  logic [3:0]        dim,
`endif
  output logic [N_CH-1:0]   led
);

  localparam int PRESC_RAW = CLK_HZ / TICK_HZ;
  localparam int PRESC = (PRESC_RAW > 1) ? PRESC_RAW : 1;
  localparam int PW = $clog2(PRESC) + 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);
  localparam logic [7:0] HB_PAT = 8'b0000_0101;

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_ON    = 2'b01,
    M_BLINK = 2'b10,
    M_HB    = 2'b11
  } mode_e;

  logic [PW-1:0]     presc_q;
  logic              tick;
  mode_e             mode_q  [N_CH];
  logic [HALF_W-1:0] half_q  [N_CH];
  logic [HALF_W-1:0] cnt_q   [N_CH];
  logic [2:0]        phase_q [N_CH];
  logic [HALF_W-1:0] hm1     [N_CH];
  logic [N_CH-1:0]   wr_hit;
  logic [N_CH-1:0]   dec;
  logic              gate;

  assign tick = en && (presc_q == P_LAST);

  // Prescaler: free count while enabled, parked at 0 otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (!en || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Write hit and effective half-period minus one per channel
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = cfg_we && (int'(cfg_ch) == i);
      hm1[i]    = (half_q[i] == '0) ? '0
                : half_q[i] - 1'b1;
    end
  end

  // Channel state: cfg write beats mode change beats tick
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]  <= M_OFF;
        half_q[i]  <= HALF_W'(DEF_HALF);
        cnt_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= mode_e'(mode[2*i +: 2]);
        if (wr_hit[i]) begin
          half_q[i]  <= cfg_half;
          cnt_q[i]   <= '0;
          phase_q[i] <= '0;
        end else if (mode_e'(mode[2*i +: 2]) != mode_q[i]) begin
          cnt_q[i]   <= '0;
          phase_q[i] <= '0;
        end else if (mode_q[i] == M_OFF || mode_q[i] == M_ON) begin
          cnt_q[i]   <= '0;
          phase_q[i] <= '0;
        end else if (tick) begin
          if (cnt_q[i] >= hm1[i]) begin
            cnt_q[i]   <= '0;
            phase_q[i] <= phase_q[i] + 3'd1;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // Pattern decode from registered mode and phase
  always_comb begin
    dec = '0;
    for (int i = 0; i < N_CH; i++) begin
      unique case (mode_q[i])
        M_OFF:   dec[i] = 1'b0;
        M_ON:    dec[i] = 1'b1;
        M_BLINK: dec[i] = ~phase_q[i][0];
        M_HB:    dec[i] = HB_PAT[phase_q[i]];
      endcase
    end
  end

`ifdef BLINKER_PWM_DIM_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM ramp for global dimming
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign gate = (pwm_cnt <= dim);
`else
  assign gate = 1'b1;
`endif

  // Registered LED drive
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= dec & {N_CH{gate}};
    end
  end

endmodule

// File: tb/tb_multi_ch_blinker.sv
// tb_multi_ch_blinker: scoreboard bench, PRESC=10, DEF_HALF=5.
// Second instance with N_CH=3 exercises an out-of-range cfg_ch.
module tb_multi_ch_blinker;

  localparam int T = 4;

  typedef struct {
    int         cyc;
    logic       b;
    logic [3:0] mask;
    logic [3:0] exp;
    string      name;
  } chk_t;

  chk_t q[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] mode = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [9:0] cfg_half = '0;
  logic [3:0] led;
  logic [5:0] mode_b = '0;
  logic       cfg_we_b = 1'b0;
  logic [1:0] cfg_ch_b = '0;
  logic [9:0] cfg_half_b = '0;
  logic [2:0] led_b;
  logic [3:0] dim = 4'hF;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int tick_en0 = 0;

  multi_ch_blinker #(
    .CLK_HZ(1000), .TICK_HZ(100), .N_CH(4),
    .HALF_W(10), .DEF_HALF(5)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
`ifdef BLINKER_PWM_DIM_EN
    .dim(dim),
`endif
    .led(led)
  );

  multi_ch_blinker #(
    .CLK_HZ(1000), .TICK_HZ(100), .N_CH(3),
    .HALF_W(10), .DEF_HALF(5)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode_b),
    .cfg_we(cfg_we_b), .cfg_ch(cfg_ch_b),
    .cfg_half(cfg_half_b),
`ifdef BLINKER_PWM_DIM_EN
    .dim(dim),
`endif
    .led(led_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int r, input logic b,
                           input logic [3:0] m,
                           input logic [3:0] e,
                           input string n);
    chk_t x;
    x.cyc = T + r;
    x.b = b;
    x.mask = m;
    x.exp = e;
    x.name = n;
    q.push_back(x);
  endtask

  task automatic at(input int r);
    while (cyc < T + r) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: retire every scoreboard entry due this cycle
  always @(negedge clk) begin
    logic [3:0] obs;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        obs = q[i].b ? {1'b0, led_b} : led;
        checks++;
        if (q[i].cyc != cyc) begin
          errors++;
          $display("FAIL %s: due cycle %0d missed at %0d",
                   q[i].name, q[i].cyc, cyc);
        end else if ((obs & q[i].mask) !== q[i].exp) begin
          errors++;
          $display("FAIL %s @%0d: led=%b required=%b mask=%b",
                   q[i].name, cyc, obs & q[i].mask,
                   q[i].exp, q[i].mask);
        end
        q.delete(i);
      end
    end
    if (!en && u_a.tick) tick_en0++;
  end

  initial begin
    for (int r = -3; r <= 0; r++)
      expect_at(r, 1'b0, 4'hF, 4'h0, "reset");
    expect_at(0, 1'b1, 4'h7, 4'h0, "reset_b");
    at(0);

    // ch0 BLINK, ch1 HB, ch2 BLINK, ch3 ON
    rst = 1'b0;
    en = 1'b1;
    mode = 8'b0110_1110;
    mode_b = 6'b10_10_10;
    expect_at(1,   1'b0, 4'hF, 4'h0, "latency");
    expect_at(2,   1'b0, 4'hF, 4'hF, "first_lit");
    expect_at(50,  1'b0, 4'hF, 4'hF, "lit_end");
    expect_at(51,  1'b0, 4'hF, 4'h8, "dark");
    expect_at(100, 1'b0, 4'hF, 4'h8, "dark_end");
    expect_at(101, 1'b0, 4'hF, 4'hF, "relit");
    expect_at(150, 1'b0, 4'hF, 4'hF, "hb_beat2");
    expect_at(151, 1'b0, 4'hF, 4'h8, "hb_gap");
    expect_at(250, 1'b0, 4'hF, 4'hD, "hb_dark");
    expect_at(400, 1'b0, 4'hF, 4'h8, "hb_tail");
    expect_at(401, 1'b0, 4'hF, 4'hF, "phase_wrap");
    expect_at(2,   1'b1, 4'h7, 4'h7, "b_lit");
    expect_at(51,  1'b1, 4'h7, 4'h0, "b_dark");

    // ch2 half=2 while dark; u_b write to ch3 (absent)
    at(460);
    cfg_we = 1'b1;
    cfg_ch = 2'd2;
    cfg_half = 10'd2;
    cfg_we_b = 1'b1;
    cfg_ch_b = 2'd3;
    cfg_half_b = 10'd1;
    expect_at(461, 1'b0, 4'h4, 4'h0, "wr_before");
    expect_at(462, 1'b0, 4'h4, 4'h4, "wr_restart");
    expect_at(480, 1'b0, 4'h4, 4'h4, "h2_lit");
    expect_at(481, 1'b0, 4'h4, 4'h0, "h2_dark");
    expect_at(500, 1'b0, 4'h4, 4'h0, "h2_dark_end");
    expect_at(501, 1'b0, 4'h4, 4'h4, "h2_relit");
    expect_at(462, 1'b1, 4'h7, 4'h0, "ign_dark");
    expect_at(500, 1'b1, 4'h7, 4'h0, "ign_dark_end");
    expect_at(501, 1'b1, 4'h7, 4'h7, "ign_lit");
    at(461);
    cfg_we = 1'b0;
    cfg_we_b = 1'b0;

    // ch3 BLINK with half=0 -> h=1
    at(505);
    mode = 8'b1010_1110;
    cfg_we = 1'b1;
    cfg_ch = 2'd3;
    cfg_half = 10'd0;
    expect_at(506, 1'b0, 4'h8, 4'h8, "h1_prev_on");
    expect_at(507, 1'b0, 4'h8, 4'h8, "h1_lit");
    expect_at(510, 1'b0, 4'h8, 4'h8, "h1_lit_end");
    expect_at(511, 1'b0, 4'h8, 4'h0, "h1_dark");
    expect_at(520, 1'b0, 4'h8, 4'h0, "h1_dark_end");
    expect_at(521, 1'b0, 4'h8, 4'h8, "h1_relit");
    expect_at(531, 1'b0, 4'h8, 4'h0, "h1_dark2");
    at(506);
    cfg_we = 1'b0;

    // en low 200 clks in ch0 lit phase 12 (cnt=2)
    at(620);
    en = 1'b0;
    expect_at(640, 1'b0, 4'h1, 4'h1, "frz_a");
    expect_at(700, 1'b0, 4'h1, 4'h1, "frz_b");
    expect_at(800, 1'b0, 4'h1, 4'h1, "frz_c");
    expect_at(850, 1'b0, 4'h1, 4'h1, "resume_lit");
    expect_at(851, 1'b0, 4'h1, 4'h0, "resume_dark");
    at(820);
    en = 1'b1;

    // ch3 ON, then reset mid-pattern
    at(855);
    mode = 8'b0110_1110;
    expect_at(858, 1'b0, 4'h8, 4'h8, "on_pre_rst");
    expect_at(861, 1'b0, 4'hF, 4'h0, "rst_mid");
    expect_at(862, 1'b0, 4'hF, 4'h0, "rst_hold");
    expect_at(863, 1'b0, 4'hF, 4'h0, "rst_lat");
    expect_at(864, 1'b0, 4'hF, 4'hF, "post_rst");
    expect_at(883, 1'b0, 4'h7, 4'h7, "def_half");
    expect_at(912, 1'b0, 4'h7, 4'h7, "def_lit_end");
    expect_at(913, 1'b0, 4'h7, 4'h0, "def_dark");
    at(860);
    rst = 1'b1;
    at(862);
    rst = 1'b0;

    at(920);
    for (int k = 0; k < 50 && q.size() > 0; k++)
      @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d checks pending, required 0",
               q.size());
    end
    checks++;
    if (tick_en0 != 0) begin
      errors++;
      $display("FAIL tick_en0: pulses=%0d required=0",
               tick_en0);
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: cycle=%0d required<=%0d",
             cyc, T + 970);
    $fatal(1, "timeout");
  end

endmodule
